pipe_stage_hs: RTL and testbench

- Parametrised inter-stage pipeline register with valid/ready handshake, a 2-entry skid buffer, and synchronous flush.
- Sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and replaces the fixed-field stage registers.
- Carries a datapath bundle and a control bundle. The control bundle is forced to zero whenever the stage holds a bubble, so downstream write/read enables are never spuriously asserted.

---
 rtl/pipe_stage_hs.sv | 193 +++++++++++++++++++
 tb/tb_pipe_stage_hs.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_hs.sv
// ---------------------------------------------------------------------------
// pipe_stage_hs
//   Inter-stage pipeline register with a valid/ready handshake, a 2-entry
//   skid buffer (main register M plus skid register S) and a synchronous
//   flush. It replaces the fixed-field stage registers between IF/ID, ID/EX,
//   EX/MEM and MEM/WB. The control bundle is forced to zero while the stage
//   holds a bubble, so downstream enables never fire spuriously.
//
//   in_ready comes straight from a flop (!S.valid). It never depends
//   combinationally on out_ready, so a ready path cannot chain through
//   several stages.
//
// Parameters
//   DATA_W  width of the datapath bundle
//   CTRL_W  width of the control bundle (all-zero = NOP)
//   CNT_W   width of the performance counters (used with PIPE_STAGE_PERF_EN)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous, active-high reset
//   flush      synchronous squash of all held entries
//   in_valid   upstream has a bundle        in_ready   stage can accept
//   in_data    upstream datapath bundle     in_ctrl    upstream control
//   out_valid  bundle presented downstream  out_ready  downstream consumes
//   out_data   registered datapath bundle (holds its value while invalid)
//   out_ctrl   registered control bundle, zero while out_valid = 0
//   stall_cnt  cycles with out_valid & !out_ready       (PIPE_STAGE_PERF_EN)
//   flush_cnt  valid entries discarded by flush         (PIPE_STAGE_PERF_EN)
//
// Optional feature macro: PIPE_STAGE_PERF_EN adds the two saturating
// performance counters. When the macro is undefined the ports and the
// counter logic are absent.
//
// State   | meaning
// --------+-------------------------------------------
// EMPTY   | M empty, S empty
// ONE     | M valid, S empty
// FULL    | M valid, S valid (in_ready low)
// ---------------------------------------------------------------------------
module pipe_stage_hs #(
   parameter int DATA_W = 64,
   parameter int CTRL_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
`endif
);

   if (CNT_W < 1) begin : g_cnt_w_check
      $error("pipe_stage_hs: CNT_W must be at least 1");
   end

   // Encoding is {S.valid, M.valid}, so the valid bits are the state itself.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_FULL  = 2'b11
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic [DATA_W-1:0]   m_data;
   logic [CTRL_W-1:0]   m_ctrl;
   logic [DATA_W-1:0]   s_data;
   logic [CTRL_W-1:0]   s_ctrl;
   logic                m_valid;
   logic                s_valid;
   logic                accept;
   logic                consume;
   logic                load_m_in;
   logic                load_m_skid;
   logic                load_s;

   assign m_valid   = state_q[0];
   assign s_valid   = state_q[1];
   assign in_ready  = ~s_valid;
   assign out_valid = m_valid;
   assign out_data  = m_data;
   assign out_ctrl  = m_valid ? m_ctrl : '0;
   assign accept    = in_valid & in_ready;
   assign consume   = out_valid & out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      load_m_in   = 1'b0;
      load_m_skid = 1'b0;
      load_s      = 1'b0;
      if (flush) begin
         // Storage is squashed; no register is loaded, so out_data keeps
         // its old value and the offered bundle is dropped.
         state_d = ST_EMPTY;
      end else begin
         unique case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  load_m_in = 1'b1;
                  state_d   = ST_ONE;
               end
            end
            ST_ONE: begin
               if (accept && consume) begin
                  load_m_in = 1'b1;
               end else if (accept) begin
                  load_s  = 1'b1;
                  state_d = ST_FULL;
               end else if (consume) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (consume) begin
                  load_m_skid = 1'b1;
                  state_d     = ST_ONE;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_data <= '0;
         m_ctrl <= '0;
         s_data <= '0;
         s_ctrl <= '0;
      end else begin
         if (load_m_in) begin
            m_data <= in_data;
            m_ctrl <= in_ctrl;
         end else if (load_m_skid) begin
            m_data <= s_data;
            m_ctrl <= s_ctrl;
         end
         if (load_s) begin
            s_data <= in_data;
            s_ctrl <= in_ctrl;
         end
      end
   end

`ifdef PIPE_STAGE_PERF_EN
   // Entries lost to a flush: whatever is held, minus M if it is consumed
   // in the same cycle (it was delivered, not discarded).
   logic [1:0]       flush_lost;
   logic [CNT_W:0]   flush_sum;

   assign flush_lost = {1'b0, m_valid} + {1'b0, s_valid} - {1'b0, consume};
   assign flush_sum  = {1'b0, flush_cnt} + (CNT_W+1)'(flush_lost);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (out_valid && !out_ready && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
         if (flush) begin
            flush_cnt <= flush_sum[CNT_W] ? '1 : flush_sum[CNT_W-1:0];
         end
      end
   end
`endif

   // Upstream must keep offering a bundle until it is taken, unless a flush
   // squashes the offer.
   a_hold_offer: assert property (@(posedge clk) disable iff (rst)
      (in_valid && !in_ready && !flush) |=> (in_valid || flush));

endmodule

// File: tb/tb_pipe_stage_hs.sv
module tb_pipe_stage_hs;

   localparam int DATA_W = 64;
   localparam int CTRL_W = 16;
   localparam int CNT_W  = 4;
   localparam int CNT_MAX = 15;

   logic              clk;
   logic              rst;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [CTRL_W-1:0] in_ctrl;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CTRL_W-1:0] out_ctrl;
`ifdef PIPE_STAGE_PERF_EN
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  flush_cnt;
`endif

   pipe_stage_hs #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_ctrl   (in_ctrl),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ctrl  (out_ctrl)
`ifdef PIPE_STAGE_PERF_EN
      ,
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic [DATA_W-1:0] d;
      logic [CTRL_W-1:0] c;
   } item_t;

   // Reference model: the stage is a FIFO of at most two bundles.
   item_t             q[$];
   logic [DATA_W-1:0] last_front;
   int                stall_m;
   int                flush_m;
   int                checks;
   int                errors;

   function automatic int sat(input int v);
      return (v > CNT_MAX) ? CNT_MAX : v;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      last_front = '0;
      stall_m    = 0;
      flush_m    = 0;
   endtask

   task automatic check_outputs(input string tag);
      if (q.size() > 0) last_front = q[0].d;
      check({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() > 0));
      check({tag, ".in_ready"},  64'(in_ready),  64'(q.size() < 2));
      check({tag, ".out_data"},  out_data,       last_front);
      check({tag, ".out_ctrl"},  64'(out_ctrl),  (q.size() > 0) ? 64'(q[0].c) : 64'd0);
`ifdef PIPE_STAGE_PERF_EN
      check({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(stall_m));
      check({tag, ".flush_cnt"}, 64'(flush_cnt), 64'(flush_m));
`endif
   endtask

   // One clock: drive inputs, check state-derived outputs, clock, update model.
   task automatic cycle(input string tag, input logic iv, input logic [DATA_W-1:0] d,
                        input logic [CTRL_W-1:0] c, input logic ordy, input logic fl);
      bit    acc;
      bit    cons;
      item_t it;
      in_valid  = iv;
      in_data   = d;
      in_ctrl   = c;
      out_ready = ordy;
      flush     = fl;
      #1;
      check_outputs(tag);
      acc  = iv && (q.size() < 2);
      cons = ordy && (q.size() > 0);
      if (q.size() > 0 && !ordy) stall_m = sat(stall_m + 1);
      @(posedge clk);
      if (fl) begin
         flush_m = sat(flush_m + q.size() - int'(cons));
         q.delete();
      end else begin
         if (cons) void'(q.pop_front());
         if (acc) begin
            it.d = d;
            it.c = c;
            q.push_back(it);
         end
      end
      #1;
   endtask

   bit                have_offer;
   logic [DATA_W-1:0] od;
   logic [CTRL_W-1:0] oc;
   bit                ordy_r;
   bit                fl_r;
   bit                acc_pred;

   initial begin
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_ctrl   = '0;
      out_ready = 1'b0;
      model_reset();

      // Reset values
      #12;
      check_outputs("reset");
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Streaming 0x01..0x08 at full throughput
      for (int i = 1; i <= 8; i++)
         cycle("stream", 1'b1, DATA_W'(i), CTRL_W'(16'h0100 + i), 1'b1, 1'b0);
      cycle("stream_drain", 1'b0, '0, '0, 1'b1, 1'b0);
      cycle("stream_idle", 1'b0, '0, '0, 1'b1, 1'b0);

      // Backpressure: A1, A2 fill the stage, A3 waits upstream
      cycle("bp_a1", 1'b1, 64'hA1, 16'h00A1, 1'b0, 1'b0);
      cycle("bp_a2", 1'b1, 64'hA2, 16'h00A2, 1'b0, 1'b0);
      cycle("bp_full", 1'b1, 64'hA3, 16'h00A3, 1'b0, 1'b0);
      check("bp_full_in_ready", 64'(in_ready), 64'd0);
      cycle("bp_rel1", 1'b1, 64'hA3, 16'h00A3, 1'b1, 1'b0);
      cycle("bp_rel2", 1'b1, 64'hA3, 16'h00A3, 1'b1, 1'b0);
      cycle("bp_rel3", 1'b0, '0, '0, 1'b1, 1'b0);
      cycle("bp_idle", 1'b0, '0, '0, 1'b1, 1'b0);

      // Flush in FULL with an offered all-ones control bundle
      cycle("fl_fill1", 1'b1, 64'hB1, 16'h00B1, 1'b0, 1'b0);
      cycle("fl_fill2", 1'b1, 64'hB2, 16'h00B2, 1'b0, 1'b0);
      cycle("fl_full", 1'b1, 64'hB3, 16'hFFFF, 1'b0, 1'b1);
      check("fl_after_ctrl", 64'(out_ctrl), 64'd0);
`ifdef PIPE_STAGE_PERF_EN
      check("fl_after_cnt", 64'(flush_cnt), 64'd2);
`endif
      cycle("fl_idle", 1'b0, '0, '0, 1'b1, 1'b0);

      // Flush together with consume in ONE
      cycle("flc_fill", 1'b1, 64'hC1, 16'h00C1, 1'b0, 1'b0);
      cycle("flc_both", 1'b0, '0, '0, 1'b1, 1'b1);
      cycle("flc_idle", 1'b0, '0, '0, 1'b1, 1'b0);

      // Asynchronous reset in the middle of a cycle while FULL
      cycle("rst_fill1", 1'b1, 64'hD1, 16'h00D1, 1'b0, 1'b0);
      cycle("rst_fill2", 1'b1, 64'hD2, 16'h00D2, 1'b0, 1'b0);
      in_valid = 1'b0;
      #3;
      rst = 1'b1;
      #1;
      model_reset();
      check_outputs("rst_async");
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
      cycle("rst_after1", 1'b0, '0, '0, 1'b1, 1'b0);
      cycle("rst_after2", 1'b0, '0, '0, 1'b1, 1'b0);

      // Stall counter saturation
      cycle("sat_fill", 1'b1, 64'hE1, 16'h00E1, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++)
         cycle("sat_hold", 1'b0, '0, '0, 1'b0, 1'b0);
`ifdef PIPE_STAGE_PERF_EN
      check("sat_stall_cnt", 64'(stall_cnt), 64'hF);
`endif
      cycle("sat_drain", 1'b0, '0, '0, 1'b1, 1'b0);

      // Randomized traffic against the FIFO model
      have_offer = 1'b0;
      od = '0;
      oc = '0;
      for (int i = 0; i < 400; i++) begin
         if (!have_offer && $urandom_range(3) != 0) begin
            have_offer = 1'b1;
            od = {$urandom, $urandom};
            oc = CTRL_W'($urandom);
         end
         ordy_r   = ($urandom_range(2) != 0);
         fl_r     = ($urandom_range(19) == 0);
         acc_pred = have_offer && (q.size() < 2);
         cycle("rand", have_offer, od, oc, ordy_r, fl_r);
         if (acc_pred || fl_r) have_offer = 1'b0;
      end
      cycle("rand_end", 1'b0, '0, '0, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
